// File: rtl/rp_stream_decoupler.sv
// rp_stream_decoupler: drains and gates AXI-Stream traffic around a reconfigurable partition
// Ports:
//   axis_aclk, axis_reset      clock, asynchronous active-high reset
//   decouple_req/decouple_ack  level request / acknowledge (ack only in DECOUPLED)
//   outstanding                packets currently inside the partition
//   err_underflow              sticky: egress tlast seen with nothing outstanding
//   err_timeout                sticky: drain timeout fired (RP_DECOUPLE_TIMEOUT_EN only, else 0)
//   s_axis_*  -> m_rp_axis_*   ingress, upstream to partition slave port
//   s_rp_axis_* -> m_axis_*    egress, partition master port to downstream
// Build option: define RP_DECOUPLE_TIMEOUT_EN to add the drain timeout.
module rp_stream_decoupler #(
  parameter int          AXIS_DATA_WIDTH  = 512,
  parameter int          AXIS_TUSER_WIDTH = 256,
  parameter int          CNT_WIDTH        = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input  logic                          axis_aclk,
  input  logic                          axis_reset,
  input  logic                          decouple_req,
  output logic                          decouple_ack,
  output logic [CNT_WIDTH-1:0]          outstanding,
  output logic                          err_underflow,
  output logic                          err_timeout,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_rp_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_rp_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_rp_axis_tuser,
  output logic                          m_rp_axis_tvalid,
  input  logic                          m_rp_axis_tready,
  output logic                          m_rp_axis_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_rp_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_rp_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_rp_axis_tuser,
  input  logic                          s_rp_axis_tvalid,
  output logic                          s_rp_axis_tready,
  input  logic                          s_rp_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);
  typedef enum logic [1:0] {RUN, DRAIN_IN, DRAIN_RP, DECOUPLED} state_t;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_pkt_q, in_pkt_d;
  logic                 uf_q, uf_d;
  logic                 gate_in, gate_out, in_acc, in_last, out_last, release_rp, tmo_fire;
  // A saturated counter closes the ingress gate so it can never wrap.
  assign gate_in  = (state_q == RUN && !(&cnt_q)) || (state_q == DRAIN_IN && in_pkt_q);
  assign gate_out = state_q != DECOUPLED;
  assign m_rp_axis_tdata  = s_axis_tdata;
  assign m_rp_axis_tkeep  = s_axis_tkeep;
  assign m_rp_axis_tuser  = s_axis_tuser;
  assign m_rp_axis_tlast  = s_axis_tlast;
  assign m_rp_axis_tvalid = s_axis_tvalid & gate_in;
  assign s_axis_tready    = m_rp_axis_tready & gate_in;
  assign m_axis_tdata     = s_rp_axis_tdata;
  assign m_axis_tkeep     = s_rp_axis_tkeep;
  assign m_axis_tuser     = s_rp_axis_tuser;
  assign m_axis_tlast     = s_rp_axis_tlast;
  assign m_axis_tvalid    = s_rp_axis_tvalid & gate_out;
  assign s_rp_axis_tready = m_axis_tready & gate_out;
  assign in_acc     = s_axis_tvalid & s_axis_tready;
  assign in_last    = in_acc & s_axis_tlast;
  assign out_last   = s_rp_axis_tvalid & s_rp_axis_tready & s_rp_axis_tlast;
  // Leaving DECOUPLED means the partition was swapped: forget what was inside.
  assign release_rp = state_q == DECOUPLED && !decouple_req;
  assign decouple_ack  = state_q == DECOUPLED;
  assign outstanding   = cnt_q;
  assign err_underflow = uf_q;
`ifdef RP_DECOUPLE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_err_q, tmo_err_d, draining;
  assign draining = state_q == DRAIN_IN || state_q == DRAIN_RP;
  // Abort wins over timeout, so the timeout only fires while the request holds.
  assign tmo_fire = draining && decouple_req && (tmo_q + 32'd1 == TIMEOUT_CYCLES);
  always_comb begin
    tmo_d     = (draining && (state_d == DRAIN_IN || state_d == DRAIN_RP)) ? tmo_q + 32'd1 : 32'd0;
    tmo_err_d = release_rp ? 1'b0 : (tmo_err_q | tmo_fire);
  end
  always_ff @(posedge axis_aclk or posedge axis_reset)
    if (axis_reset) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  assign err_timeout = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign tmo_fire    = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:       state_d = decouple_req ? DRAIN_IN : RUN;
      DRAIN_IN:  state_d = !decouple_req ? RUN : tmo_fire ? DECOUPLED : !in_pkt_q ? DRAIN_RP : DRAIN_IN;
      DRAIN_RP:  state_d = !decouple_req ? RUN : (tmo_fire || cnt_q == '0) ? DECOUPLED : DRAIN_RP;
      DECOUPLED: state_d = decouple_req ? DECOUPLED : RUN;
      default:   state_d = RUN;
    endcase
  end
  always_comb begin
    cnt_d    = cnt_q;
    uf_d     = uf_q;
    in_pkt_d = release_rp ? 1'b0 : in_acc ? !s_axis_tlast : in_pkt_q;
    if (release_rp)
      cnt_d = '0;
    else if (in_last && !out_last)
      cnt_d = cnt_q + CNT_WIDTH'(1);
    else if (out_last && !in_last) begin
      if (cnt_q == '0)
        uf_d = 1'b1;
      else
        cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end
  always_ff @(posedge axis_aclk or posedge axis_reset)
    if (axis_reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      in_pkt_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_pkt_q <= in_pkt_d;
      uf_q     <= uf_d;
    end
endmodule

// File: tb/tb_rp_stream_decoupler.sv
// tb_rp_stream_decoupler: directed self-checking bench for rp_stream_decoupler
module tb_rp_stream_decoupler;
  localparam int DW = 32;
  localparam int UW = 8;
  logic          clk = 1'b0;
  logic          axis_reset, decouple_req, decouple_ack, err_underflow, err_timeout;
  logic [7:0]    outstanding;
  logic [DW-1:0] s_axis_tdata, m_rp_axis_tdata, s_rp_axis_tdata, m_axis_tdata;
  logic [DW/8-1:0] s_axis_tkeep, m_rp_axis_tkeep, s_rp_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0] s_axis_tuser, m_rp_axis_tuser, s_rp_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_rp_axis_tvalid, m_rp_axis_tready, m_rp_axis_tlast;
  logic          s_rp_axis_tvalid, s_rp_axis_tready, s_rp_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  int            n_cmp = 0;
  int            n_err = 0;
  rp_stream_decoupler #(
    .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .CNT_WIDTH(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .axis_aclk(clk), .axis_reset(axis_reset), .decouple_req(decouple_req), .decouple_ack(decouple_ack),
    .outstanding(outstanding), .err_underflow(err_underflow), .err_timeout(err_timeout),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_rp_axis_tdata(m_rp_axis_tdata), .m_rp_axis_tkeep(m_rp_axis_tkeep), .m_rp_axis_tuser(m_rp_axis_tuser),
    .m_rp_axis_tvalid(m_rp_axis_tvalid), .m_rp_axis_tready(m_rp_axis_tready), .m_rp_axis_tlast(m_rp_axis_tlast),
    .s_rp_axis_tdata(s_rp_axis_tdata), .s_rp_axis_tkeep(s_rp_axis_tkeep), .s_rp_axis_tuser(s_rp_axis_tuser),
    .s_rp_axis_tvalid(s_rp_axis_tvalid), .s_rp_axis_tready(s_rp_axis_tready), .s_rp_axis_tlast(s_rp_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    axis_reset = 1'b1; decouple_req = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5A5_0001; s_axis_tkeep = 4'hF; s_axis_tuser = 8'h3C; s_axis_tlast = 1'b1;
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tdata = 32'h5A5A_0002; s_rp_axis_tkeep = 4'h3; s_rp_axis_tuser = 8'hC3; s_rp_axis_tlast = 1'b1;
    m_rp_axis_tready = 1'b1; m_axis_tready = 1'b1;
    repeat (2) tick;
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%0h exp=0", decouple_ack); end
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%0h exp=0", err_underflow); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%0h exp=0", err_timeout); end
    n_cmp++; if (m_rp_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL reset_in_valid got=%0h exp=1", m_rp_axis_tvalid); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0h exp=1", s_axis_tready); end
    n_cmp++; if ({m_rp_axis_tdata, m_rp_axis_tkeep, m_rp_axis_tuser, m_rp_axis_tlast} !== {32'hA5A5_0001, 4'hF, 8'h3C, 1'b1})
      begin n_err++; $display("FAIL reset_in_pass got=%0h/%0h/%0h/%0h exp=a5a50001/f/3c/1", m_rp_axis_tdata, m_rp_axis_tkeep, m_rp_axis_tuser, m_rp_axis_tlast); end
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL reset_out_valid got=%0h exp=1", m_axis_tvalid); end
    n_cmp++; if (s_rp_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_out_ready got=%0h exp=1", s_rp_axis_tready); end
    n_cmp++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== {32'h5A5A_0002, 4'h3, 8'hC3, 1'b1})
      begin n_err++; $display("FAIL reset_out_pass got=%0h/%0h/%0h/%0h exp=5a5a0002/3/c3/1", m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast); end
    s_axis_tvalid = 1'b0; s_rp_axis_tvalid = 1'b0;
    axis_reset = 1'b0;
    tick;
  endtask
  task automatic test_idle_decouple;
    decouple_req = 1'b1;
    #1;
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_n got=%0h exp=0", decouple_ack); end
    repeat (2) tick;
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_n2 got=%0h exp=0", decouple_ack); end
    tick;
    n_cmp++; if (decouple_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack_n3 got=%0h exp=1", decouple_ack); end
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b0;
    #1;
    n_cmp++; if ({s_axis_tready, m_rp_axis_tvalid} !== 2'b00) begin n_err++; $display("FAIL idle_in_gate got=%b exp=00", {s_axis_tready, m_rp_axis_tvalid}); end
    n_cmp++; if ({s_rp_axis_tready, m_axis_tvalid} !== 2'b00) begin n_err++; $display("FAIL idle_out_gate got=%b exp=00", {s_rp_axis_tready, m_axis_tvalid}); end
    repeat (6) tick;
    s_axis_tvalid = 1'b0; s_rp_axis_tvalid = 1'b0; decouple_req = 1'b0;
    #1;
    n_cmp++; if (decouple_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack_hold got=%0h exp=1", decouple_ack); end
    tick;
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_fall got=%0h exp=0", decouple_ack); end
    s_axis_tvalid = 1'b1;
    #1;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL idle_reopen got=%0h exp=1", s_axis_tready); end
    s_axis_tvalid = 1'b0;
  endtask
  task automatic test_mid_packet;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 32'd1;
    tick;
    s_axis_tdata = 32'd2;
    tick;
    s_axis_tdata = 32'd3; decouple_req = 1'b1;
    #1;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL mid_beat3_ready got=%0h exp=1", s_axis_tready); end
    tick;
    s_axis_tdata = 32'd4; s_axis_tlast = 1'b1;
    #1;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL mid_beat4_ready got=%0h exp=1", s_axis_tready); end
    n_cmp++; if (m_rp_axis_tdata !== 32'd4) begin n_err++; $display("FAIL mid_beat4_data got=%0h exp=4", m_rp_axis_tdata); end
    tick;
    n_cmp++; if (outstanding !== 8'd1) begin n_err++; $display("FAIL mid_out1 got=%0d exp=1", outstanding); end
    s_axis_tdata = 32'd5; s_axis_tlast = 1'b0;
    #1;
    n_cmp++; if ({s_axis_tready, m_rp_axis_tvalid} !== 2'b00) begin n_err++; $display("FAIL mid_next_held got=%b exp=00", {s_axis_tready, m_rp_axis_tvalid}); end
    repeat (5) tick;
    n_cmp++; if ({decouple_ack, s_axis_tready} !== 2'b00) begin n_err++; $display("FAIL mid_wait got=%b exp=00", {decouple_ack, s_axis_tready}); end
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1; s_rp_axis_tdata = 32'd4; m_axis_tready = 1'b1;
    #1;
    n_cmp++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'd4}) begin n_err++; $display("FAIL mid_egress got=%0h/%0h exp=1/4", m_axis_tvalid, m_axis_tdata); end
    tick;
    s_rp_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL mid_out0 got=%0d exp=0", outstanding); end
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL mid_ack_early got=%0h exp=0", decouple_ack); end
    tick;
    n_cmp++; if (decouple_ack !== 1'b1) begin n_err++; $display("FAIL mid_ack got=%0h exp=1", decouple_ack); end
    n_cmp++; if ({s_axis_tvalid, s_axis_tready, m_rp_axis_tvalid} !== 3'b100) begin n_err++; $display("FAIL mid_still_held got=%b exp=100", {s_axis_tvalid, s_axis_tready, m_rp_axis_tvalid}); end
    s_axis_tvalid = 1'b0; decouple_req = 1'b0;
    tick;
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL mid_release got=%0h exp=0", decouple_ack); end
  endtask
  task automatic test_backpressure;
    logic [31:0] q[$];
    int sent = 0;
    int rcv = 0;
    logic acc_in, acc_out;
    m_axis_tready = 1'b1;
    for (int cyc = 0; cyc < 300 && rcv < 20; cyc++) begin
      s_axis_tvalid = sent < 20; s_axis_tdata = sent; s_axis_tlast = 1'b1;
      m_rp_axis_tready = (cyc % 2) == 1;
      s_rp_axis_tvalid = q.size() > 0; s_rp_axis_tdata = q.size() > 0 ? q[0] : 32'd0; s_rp_axis_tlast = 1'b1;
      #1;
      n_cmp++; if (s_axis_tready !== m_rp_axis_tready) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%0h exp=%0h", cyc, s_axis_tready, m_rp_axis_tready); end
      acc_in = m_rp_axis_tvalid && m_rp_axis_tready;
      acc_out = m_axis_tvalid && m_axis_tready;
      if (acc_out) begin
        n_cmp++; if (m_axis_tdata !== rcv) begin n_err++; $display("FAIL bp_order got=%0d exp=%0d", m_axis_tdata, rcv); end
      end
      tick;
      if (acc_in) begin q.push_back(sent); sent++; end
      if (acc_out) begin void'(q.pop_front()); rcv++; end
      n_cmp++; if (outstanding !== 8'(q.size())) begin n_err++; $display("FAIL bp_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, q.size()); end
    end
    s_axis_tvalid = 1'b0; s_rp_axis_tvalid = 1'b0; m_rp_axis_tready = 1'b1;
    n_cmp++; if (rcv !== 20) begin n_err++; $display("FAIL bp_received got=%0d exp=20", rcv); end
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL bp_end got=%0d exp=0", outstanding); end
  endtask
  task automatic test_simultaneous;
    m_rp_axis_tready = 1'b1; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    repeat (3) tick;
    s_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd3) begin n_err++; $display("FAIL sim_fill got=%0d exp=3", outstanding); end
    s_axis_tvalid = 1'b1; s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1;
    tick;
    s_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd3) begin n_err++; $display("FAIL sim_both got=%0d exp=3", outstanding); end
    repeat (3) tick;
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL sim_drain got=%0d exp=0", outstanding); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL sim_no_uf got=%0h exp=0", err_underflow); end
    tick;
    s_rp_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL sim_uf_hold got=%0d exp=0", outstanding); end
    n_cmp++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL sim_uf_set got=%0h exp=1", err_underflow); end
    tick;
    n_cmp++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL sim_uf_sticky got=%0h exp=1", err_underflow); end
  endtask
  task automatic test_abort;
    m_rp_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick;
    s_axis_tvalid = 1'b0;
    decouple_req = 1'b1; m_axis_tready = 1'b0; s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1;
    repeat (2) tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack i=%0d got=%0h exp=0", i, decouple_ack); end
    end
    n_cmp++; if (outstanding !== 8'd1) begin n_err++; $display("FAIL abort_stall got=%0d exp=1", outstanding); end
    s_axis_tvalid = 1'b1;
    #1;
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL abort_closed got=%0h exp=0", s_axis_tready); end
    decouple_req = 1'b0;
    tick;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL abort_reopen got=%0h exp=1", s_axis_tready); end
    n_cmp++; if (decouple_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack_after got=%0h exp=0", decouple_ack); end
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    tick;
    s_rp_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd0) begin n_err++; $display("FAIL abort_drain got=%0d exp=0", outstanding); end
  endtask
  task automatic test_saturation;
    m_rp_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    repeat (255) tick;
    n_cmp++; if (outstanding !== 8'd255) begin n_err++; $display("FAIL sat_count got=%0d exp=255", outstanding); end
    n_cmp++; if ({s_axis_tready, m_rp_axis_tvalid} !== 2'b00) begin n_err++; $display("FAIL sat_gate got=%b exp=00", {s_axis_tready, m_rp_axis_tvalid}); end
    tick;
    n_cmp++; if (outstanding !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", outstanding); end
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1; m_axis_tready = 1'b1;
    tick;
    s_rp_axis_tvalid = 1'b0;
    n_cmp++; if (outstanding !== 8'd254) begin n_err++; $display("FAIL sat_dec got=%0d exp=254", outstanding); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL sat_reopen got=%0h exp=1", s_axis_tready); end
    #2 axis_reset = 1'b1;
    #1;
    n_cmp++; if ({outstanding, err_underflow, decouple_ack} !== 10'd0) begin n_err++; $display("FAIL async_reset got=%0d/%0h/%0h exp=0/0/0", outstanding, err_underflow, decouple_ack); end
    s_axis_tvalid = 1'b0;
    tick;
    axis_reset = 1'b0;
    tick;
  endtask
`ifdef RP_DECOUPLE_TIMEOUT_EN
  task automatic test_timeout;
    m_rp_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick;
    s_axis_tvalid = 1'b0; decouple_req = 1'b1;
    tick;
    repeat (99) tick;
    n_cmp++; if ({decouple_ack, err_timeout} !== 2'b00) begin n_err++; $display("FAIL tmo_early got=%b exp=00", {decouple_ack, err_timeout}); end
    tick;
    n_cmp++; if ({decouple_ack, err_timeout} !== 2'b11) begin n_err++; $display("FAIL tmo_fire got=%b exp=11", {decouple_ack, err_timeout}); end
    n_cmp++; if (outstanding !== 8'd1) begin n_err++; $display("FAIL tmo_outstanding got=%0d exp=1", outstanding); end
    decouple_req = 1'b0;
    tick;
    n_cmp++; if ({outstanding, err_timeout, decouple_ack} !== 10'd0) begin n_err++; $display("FAIL tmo_release got=%0d/%0h/%0h exp=0/0/0", outstanding, err_timeout, decouple_ack); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_idle_decouple;
    test_mid_packet;
    test_backpressure;
    test_simultaneous;
    test_abort;
    test_saturation;
`ifdef RP_DECOUPLE_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rp_stream_decoupler.md
# rp_stream_decoupler

Stream decoupler placed directly upstream of `reconfigurable_partition` on the packet path. It also sits on the partition's return path. On `decouple_req` it lets the current ingress packet finish, then closes the ingress gate. It waits until every packet sent into the partition has come back out, then asserts `decouple_ack` so the partition can be saved, loaded or reconfigured without cutting packets. Both data paths are zero-latency combinational pass-throughs. Gating, packet tracking and the handshake FSM are registered.

## Interface
- `AXIS_DATA_WIDTH`, 512, tdata width of both paths.
- `AXIS_TUSER_WIDTH`, 256, tuser width of both paths.
- `CNT_WIDTH`, 8, width of the outstanding-packet counter.
- `TIMEOUT_CYCLES`, 65535, drain timeout; used only with `RP_DECOUPLE_TIMEOUT_EN`.

Ports:
- `axis_aclk` in 1: the single clock.
- `axis_reset` in 1: asynchronous, active-high reset.
- `decouple_req` in 1: level request to decouple.
- `decouple_ack` out 1: high only in DECOUPLED.
- `outstanding` out CNT_WIDTH: packets inside the partition.
- `err_underflow` out 1: sticky flag, egress tlast seen with `outstanding==0`.
- `err_timeout` out 1: sticky flag, drain timeout fired (macro only; tied 0 otherwise).
- `s_axis_*` (tdata/tkeep/tuser/tvalid/tready/tlast): upstream ingress.
- `m_rp_axis_*`: ingress to the partition slave port.
- `s_rp_axis_*`: egress from the partition master port.
- `m_axis_*`: downstream egress.

## Operation
- `gate_in` (registered-state decode):
  - Open in RUN.
  - Open in DRAIN_IN while `in_pkt`=1.
  - Closed otherwise.
  - Also closed in RUN when `outstanding` is all-ones (saturated).
- Ingress path:
  - `m_rp_axis_tvalid = s_axis_tvalid & gate_in`.
  - `s_axis_tready = m_rp_axis_tready & gate_in`.
  - Data, keep, user and last are wired straight through.
- `gate_out` is open in every state except DECOUPLED.
  - `m_axis_tvalid = s_rp_axis_tvalid & gate_out`.
  - `s_rp_axis_tready = m_axis_tready & gate_out`.
- `in_pkt` tracking:
  - Set on an accepted ingress beat with tlast=0.
  - Cleared on an accepted ingress beat with tlast=1.
- `outstanding` counter:
  - +1 on an accepted ingress tlast.
  - −1 on an accepted egress tlast.
  - Both in the same cycle: unchanged.
  - Decrement at 0: holds at 0 and sets `err_underflow`.
- FSM states, reset state RUN:
  - RUN → DRAIN_IN when `decouple_req`=1.
  - DRAIN_IN → DRAIN_RP when `in_pkt`=0 (current packet done).
  - DRAIN_IN → RUN when `decouple_req`=0 (abort).
  - DRAIN_RP → DECOUPLED when `outstanding`=0 and no decrement is pending this cycle. Equivalently, the registered count is 0.
  - DRAIN_RP → RUN when `decouple_req`=0 (abort).
  - DECOUPLED → RUN when `decouple_req`=0. On this transition, `outstanding`, `in_pkt` and `err_timeout` clear to 0, because the partition is fresh.
- Priority when transitions collide: abort beats drain progress.
- `err_underflow` clears only on reset.

## Timing
- Reset values:
  - `decouple_ack`=0.
  - `outstanding`=0.
  - `err_*`=0.
  - `in_pkt`=0.
  - State is RUN, so gates are open; all outputs equal the pass-through of their inputs.
- Datapath latency is 0 cycles; no storage and no beat reordering.
- `decouple_req` rising in cycle N:
  - The gate still follows RUN rules in cycle N, so a new packet may start in N.
  - DRAIN_IN takes effect from N+1.
- Ingress idle and `outstanding`=0 at request: `decouple_ack` rises at N+3 (RUN→DRAIN_IN→DRAIN_RP→DECOUPLED).
- `decouple_ack` falls in the cycle after `decouple_req` falls.
- Gating never drops a beat:
  - Valid is masked only together with ready.
  - A beat presented while its gate is closed stays pending upstream, unchanged.
- Reset mid-packet: everything returns to its reset value immediately (asynchronous). Partial packets are the integrator's concern.

## Configuration
- `RP_DECOUPLE_TIMEOUT_EN` defined:
  - A 32-bit counter runs in DRAIN_IN and DRAIN_RP and clears on leaving them.
  - When it reaches `TIMEOUT_CYCLES`, the FSM forces DECOUPLED and sets `err_timeout`. `outstanding` keeps its value.
- `RP_DECOUPLE_TIMEOUT_EN` undefined:
  - No counter; draining waits indefinitely.
  - `err_timeout` is tied 0.

## Test plan
- Idle decouple: no traffic, `decouple_req` 0→1 at cycle 10 → `decouple_ack`=1 at cycle 13. Release at 20 → ack=0 at 21, state RUN.
- Mid-packet request:
  - Stimulus: 4-beat ingress packet with request raised after beat 2; the partition returns the packet 6 cycles later.
  - Required: beats 3–4 are accepted, and a following packet is held with tvalid=1 and tready=0.
  - Required: `outstanding` goes 1→0, then ack rises.
- Backpressure: `m_rp_axis_tready` toggling 50% over 20 single-beat packets with egress looped back → `outstanding` never exceeds 20, ends at 0, and there are no lost or duplicated beats.
- Simultaneous events:
  - Ingress tlast and egress tlast in the same cycle at `outstanding`=3 → stays 3.
  - Egress tlast at 0 → stays 0 and `err_underflow`=1.
- Abort: raise the request, hold egress tready=0 so DRAIN_RP stalls, drop the request → RUN next cycle, ingress gate reopens, ack never asserted.
- Timeout (`RP_DECOUPLE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100): one packet never returned → ack and `err_timeout` rise 100 cycles after DRAIN_IN entry, `outstanding`=1. Release → `outstanding`=0 and `err_timeout`=0.
